// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW bubbles, load freezes with timeout,
// taken-branch flushes and HALT, plus a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter logic [6:0] OPC_LOAD     = 7'b0000011,
  parameter logic [6:0] OPC_HALT     = 7'b1111111,
  parameter int         FLUSH_CYCLES = 1,
  parameter int         MEM_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [2:0]  id_src0,
  input  logic [2:0]  id_src1,
  input  logic        id_use0,
  input  logic        id_use1,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_dest,
  input  logic        ex_wr,
  input  logic [2:0]  wb_dest,
  input  logic        wb_wr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  input  logic        resume,
  output logic        pc_halt,
  output logic        reg1_halt,
  output logic        reg1_clr,
  output logic        reg2_halt,
  output logic [1:0]  state,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_HALTED    = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [1:0] FLUSH_N = 2'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  flush_q, flush_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_q, stall_d;

  logic hit0, hit1, raw, load_stall, halt_insn;

  // Destination x0 is hardwired zero, so a write to it never creates a hazard.
  assign hit0 = id_use0 & ((ex_wr & (ex_dest != 3'd0) & (ex_dest == id_src0)) |
                           (wb_wr & (wb_dest != 3'd0) & (wb_dest == id_src0)));
  assign hit1 = id_use1 & ((ex_wr & (ex_dest != 3'd0) & (ex_dest == id_src1)) |
                           (wb_wr & (wb_dest != 3'd0) & (wb_dest == id_src1)));
  assign raw        = id_valid & (hit0 | hit1);
  assign load_stall = (ex_opcode == OPC_LOAD) & ~mem_ready;
  assign halt_insn  = id_valid & (id_opcode == OPC_HALT);

  always_comb begin
    pc_halt   = 1'b0;
    reg1_halt = 1'b0;
    reg1_clr  = 1'b0;
    reg2_halt = 1'b0;
    state_d   = state_q;
    wait_d    = wait_q;
    flush_d   = flush_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (load_stall) begin
          pc_halt   = 1'b1;
          reg1_halt = 1'b1;
          reg2_halt = 1'b1;
          state_d   = ST_LOAD_WAIT;
          wait_d    = 8'd1;
        end else if (branch_taken) begin
          reg1_clr = 1'b1;
          state_d  = ST_FLUSH;
          flush_d  = FLUSH_N;
        end else if (raw) begin
          pc_halt  = 1'b1;
          reg1_clr = 1'b1;
        end else if (halt_insn) begin
          pc_halt  = 1'b1;
          reg1_clr = 1'b1;
          state_d  = ST_HALTED;
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_q == TIMEOUT) begin
          // Forced release: the load is abandoned and the error is latched.
          state_d   = ST_RUN;
          mem_err_d = 1'b1;
        end else begin
          pc_halt   = 1'b1;
          reg1_halt = 1'b1;
          reg2_halt = 1'b1;
          wait_d    = wait_q + 8'd1;
        end
      end
      ST_FLUSH: begin
        reg1_clr = 1'b1;
        flush_d  = flush_q - 2'd1;
        if (flush_q <= 2'd1) begin
          flush_d = 2'd0;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        pc_halt  = 1'b1;
        reg1_clr = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (pc_halt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_RUN;
      wait_q    <= 8'd0;
      flush_q   <= 2'd0;
      mem_err_q <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      flush_q   <= flush_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  assign state     = state_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected outputs are queued
// by the driver and checked by an independent monitor on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] HT = 7'b1111111;
  // Control nibble order: {pc_halt, reg1_halt, reg1_clr, reg2_halt}
  localparam logic [3:0] C_NONE   = 4'b0000;
  localparam logic [3:0] C_BUBBLE = 4'b1010;
  localparam logic [3:0] C_FREEZE = 4'b1101;
  localparam logic [3:0] C_FLUSH  = 4'b0010;

  logic        clk;
  logic        nrst;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [2:0]  id_src0, id_src1;
  logic        id_use0, id_use1;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_dest;
  logic        ex_wr;
  logic [2:0]  wb_dest;
  logic        wb_wr;
  logic        mem_ready;
  logic        branch_taken;
  logic        resume;
  logic        pc_halt, reg1_halt, reg1_clr, reg2_halt;
  logic [1:0]  state;
  logic        mem_err;
  logic [15:0] stall_cnt;

  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          n_checks;
  int          n_fail;
  bit          done;

  pipe_hazard_ctrl #(
    .OPC_LOAD(LD), .OPC_HALT(HT), .FLUSH_CYCLES(1), .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk), .nrst(nrst),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src0(id_src0), .id_src1(id_src1),
    .id_use0(id_use0), .id_use1(id_use1),
    .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_wr(ex_wr),
    .wb_dest(wb_dest), .wb_wr(wb_wr),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .resume(resume),
    .pc_halt(pc_halt), .reg1_halt(reg1_halt), .reg1_clr(reg1_clr),
    .reg2_halt(reg2_halt), .state(state), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    id_valid = 0; id_opcode = 7'd0; id_src0 = 3'd0; id_src1 = 3'd0;
    id_use0 = 0; id_use1 = 0; ex_opcode = 7'd0; ex_dest = 3'd0; ex_wr = 0;
    wb_dest = 3'd0; wb_wr = 0; mem_ready = 0; branch_taken = 0; resume = 0;
  endtask

  // Queue the expected outputs for the inputs currently applied, then advance.
  task automatic cyc(input string tag, input logic [1:0] st, input logic [3:0] ctl,
                     input logic me, input logic [15:0] sc);
    exp_q.push_back({st, ctl, me, sc});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    logic [22:0] e, a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {state, pc_halt, reg1_halt, reg1_clr, reg2_halt, mem_err, stall_cnt};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got st=%0d ctl=%b me=%b sc=%0d, expected st=%0d ctl=%b me=%b sc=%0d",
                   t, a[22:21], a[20:17], a[16], a[15:0], e[22:21], e[20:17], e[16], e[15:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    n_checks = 0; n_fail = 0; done = 0;
    idle();
    nrst = 1'b0;
    @(posedge clk); #1;
    cyc("reset", 2'd0, C_NONE, 0, 16'd0);
    nrst = 1'b1;

    // RAW, producer in execute then writeback: two bubbles
    idle(); id_valid = 1; id_src0 = 3'd3; id_use0 = 1; ex_wr = 1; ex_dest = 3'd3;
    cyc("raw_ex", 2'd0, C_BUBBLE, 0, 16'd0);
    ex_wr = 0; wb_wr = 1; wb_dest = 3'd3;
    cyc("raw_wb", 2'd0, C_BUBBLE, 0, 16'd1);
    wb_wr = 0;
    cyc("raw_clear", 2'd0, C_NONE, 0, 16'd2);
    idle(); id_valid = 1; id_use0 = 1; id_src0 = 3'd0; ex_wr = 1; ex_dest = 3'd0;
    cyc("raw_x0", 2'd0, C_NONE, 0, 16'd2);
    idle(); id_valid = 1; id_use1 = 1; id_src1 = 3'd5; wb_wr = 1; wb_dest = 3'd5;
    cyc("raw_src1_wb", 2'd0, C_BUBBLE, 0, 16'd2);
    id_use1 = 0;
    cyc("raw_unused_src", 2'd0, C_NONE, 0, 16'd3);
    id_use1 = 1; id_valid = 0;
    cyc("raw_not_valid", 2'd0, C_NONE, 0, 16'd3);

    // Load waiting 3 cycles for memory
    idle(); ex_opcode = LD;
    cyc("load_first", 2'd0, C_FREEZE, 0, 16'd3);
    cyc("load_wait1", 2'd1, C_FREEZE, 0, 16'd4);
    cyc("load_wait2", 2'd1, C_FREEZE, 0, 16'd5);
    mem_ready = 1;
    cyc("load_release", 2'd1, C_NONE, 0, 16'd6);
    idle();
    cyc("load_after", 2'd0, C_NONE, 0, 16'd6);
    ex_opcode = LD; mem_ready = 1;
    cyc("load_immediate", 2'd0, C_NONE, 0, 16'd6);
    idle();
    cyc("load_imm_after", 2'd0, C_NONE, 0, 16'd6);

    // Load that never completes: 16 freeze cycles then forced release
    ex_opcode = LD;
    cyc("tmo_first", 2'd0, C_FREEZE, 0, 16'd6);
    for (int i = 0; i < 15; i++)
      cyc($sformatf("tmo_wait%0d", i + 1), 2'd1, C_FREEZE, 0, 16'(7 + i));
    cyc("tmo_release", 2'd1, C_NONE, 0, 16'd22);
    idle();
    cyc("tmo_err_sticky", 2'd0, C_NONE, 1, 16'd22);

    // Taken branch with HALT in decode: HALT squashed
    branch_taken = 1; id_valid = 1; id_opcode = HT;
    cyc("br_taken", 2'd0, C_FLUSH, 1, 16'd22);
    cyc("br_flush", 2'd2, C_FLUSH, 1, 16'd22);
    idle();
    cyc("br_back_run", 2'd0, C_NONE, 1, 16'd22);

    // HALT, ten drain cycles, resume
    id_valid = 1; id_opcode = HT;
    cyc("halt_enter", 2'd0, C_BUBBLE, 1, 16'd22);
    idle();
    for (int i = 0; i < 10; i++)
      cyc($sformatf("halted%0d", i), 2'd3, C_BUBBLE, 1, 16'(23 + i));
    resume = 1;
    cyc("halt_resume", 2'd3, C_BUBBLE, 1, 16'd33);
    resume = 0;
    cyc("halt_run", 2'd0, C_NONE, 1, 16'd34);
    resume = 1;
    cyc("resume_in_run", 2'd0, C_NONE, 1, 16'd34);
    resume = 0;
    cyc("resume_after", 2'd0, C_NONE, 1, 16'd34);

    // Priorities: load > branch > RAW > HALT
    ex_opcode = LD; branch_taken = 1; id_valid = 1; id_use0 = 1; id_src0 = 3'd3;
    ex_wr = 1; ex_dest = 3'd3;
    cyc("prio_load_br", 2'd0, C_FREEZE, 1, 16'd34);
    idle(); mem_ready = 1;
    cyc("prio_load_rel", 2'd1, C_NONE, 1, 16'd35);
    idle(); branch_taken = 1; id_valid = 1; id_use0 = 1; id_src0 = 3'd3;
    ex_wr = 1; ex_dest = 3'd3;
    cyc("prio_br_raw", 2'd0, C_FLUSH, 1, 16'd35);
    cyc("prio_br_flush", 2'd2, C_FLUSH, 1, 16'd35);
    idle();
    cyc("prio_br_done", 2'd0, C_NONE, 1, 16'd35);
    id_valid = 1; id_opcode = HT; id_use0 = 1; id_src0 = 3'd3; ex_wr = 1; ex_dest = 3'd3;
    cyc("prio_raw_halt", 2'd0, C_BUBBLE, 1, 16'd35);
    ex_wr = 0;
    cyc("prio_halt_now", 2'd0, C_BUBBLE, 1, 16'd36);
    idle(); resume = 1;
    cyc("prio_halted", 2'd3, C_BUBBLE, 1, 16'd37);
    idle();
    cyc("prio_run", 2'd0, C_NONE, 1, 16'd38);

    // Asynchronous reset in the middle of a load wait
    ex_opcode = LD;
    cyc("rst_load_first", 2'd0, C_FREEZE, 1, 16'd38);
    cyc("rst_load_wait", 2'd1, C_FREEZE, 1, 16'd39);
    nrst = 1'b0;
    cyc("rst_async", 2'd0, C_FREEZE, 0, 16'd0);
    idle();
    cyc("rst_held", 2'd0, C_NONE, 0, 16'd0);
    nrst = 1'b1;
    cyc("rst_released", 2'd0, C_NONE, 0, 16'd0);

    done = 1;
  end

  // Final report
  initial begin
    wait (done == 1'b1 || $time > 64'd20000);
    repeat (3) @(posedge clk);
    n_checks++;
    if (!done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: done=%0d pending=%0d, required done=1 pending=0", done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the RISC-V core. It drives the hold/clear controls of the decode→execute pipeline register, and the hold control of the execute→writeback pipeline register. It generates PC hold for RAW stalls, multi-cycle load waits, taken-branch flushes and the HALT instruction. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- OPC_LOAD, 7'b0000011, opcode of loads (multi-cycle memory op)
- OPC_HALT, 7'b1111111, opcode of the HALT instruction
- FLUSH_CYCLES, 1, extra bubble cycles after a taken branch (1..3)
- MEM_TIMEOUT, 16, maximum LOAD_WAIT cycles before forced release (2..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_opcode  in  7  decode-stage opcode
- id_src0, id_src1  in  3 each  decode source registers
- id_use0, id_use1  in  1 each  source actually read
- ex_opcode  in  7  execute-stage opcode (decode→execute register output)
- ex_dest  in  3  execute-stage destination
- ex_wr  in  1  execute-stage instruction writes ex_dest
- wb_dest  in  3  writeback-stage destination
- wb_wr  in  1  writeback-stage instruction writes wb_dest
- mem_ready  in  1  data memory completes the load in execute this cycle
- branch_taken  in  1  execute stage resolved a taken branch this cycle
- resume  in  1  leave HALTED (single-cycle pulse)
- pc_halt  out  1  hold PC/fetch
- reg1_halt  out  1  hold decode→execute register
- reg1_clr  out  1  load NOP into decode→execute register
- reg2_halt  out  1  hold execute→writeback register
- state  out  2  0 RUN, 1 LOAD_WAIT, 2 FLUSH, 3 HALTED
- mem_err  out  1  sticky: a load timed out
- stall_cnt  out  16  saturating count of cycles with pc_halt=1

## Operation
- Outputs pc_halt, reg1_halt, reg1_clr and reg2_halt are combinational (Mealy) from state and inputs. state, mem_err, stall_cnt, the flush counter and the wait counter are registered.
- raw = id_valid & ((id_use0 & ((ex_wr & ex_dest==id_src0) | (wb_wr & wb_dest==id_src0))) | same for src1). Register x0 (dest 0) never causes a hazard.
- RUN, priority highest first:
  1. ex_opcode==OPC_LOAD & !mem_ready: pc_halt=reg1_halt=reg2_halt=1, reg1_clr=0. Next state LOAD_WAIT; wait counter ←1.
  2. branch_taken: reg1_clr=1, pc_halt=0. Next state FLUSH; flush counter ←FLUSH_CYCLES.
  3. raw: pc_halt=1, reg1_clr=1 (bubble), reg1_halt=0. Stay in RUN.
  4. id_valid & id_opcode==OPC_HALT: pc_halt=1, reg1_clr=1. Next state HALTED.
  5. Otherwise all outputs 0.
- LOAD_WAIT:
  - If mem_ready, all outputs 0 and next state RUN.
  - Otherwise, if wait counter==MEM_TIMEOUT: outputs 0, mem_err←1, next state RUN.
  - Otherwise: full freeze (as RUN case 1), wait counter +1.
- FLUSH: reg1_clr=1, pc_halt=0. Flush counter −1; on reaching 0, next state RUN. branch_taken is ignored, since execute holds a bubble.
- HALTED: pc_halt=1, reg1_clr=1 every cycle, so execute/writeback drain. On resume, pc_halt=1 for that cycle, then next state RUN.
- stall_cnt increments in every cycle with pc_halt=1 and saturates at 16'hFFFF. mem_err clears only on reset.

## Timing
- Reset (nrst low, async): state=RUN, counters 0, mem_err=0, stall_cnt=0. Outputs then follow the RUN equations.
- Reset mid-LOAD_WAIT/FLUSH/HALTED aborts immediately to RUN; the aborted wait sets no mem_err.
- RAW stall: one bubble per cycle while the hazard persists. With the producer in execute, that is 2 bubble cycles (execute, then writeback); with the producer in writeback, 1 cycle.
- Load: freeze is asserted in the same cycle the load is seen without mem_ready. The pipeline advances in the cycle mem_ready=1. A load with mem_ready=1 in its first cycle has zero stall.
- Timeout: freeze lasts exactly MEM_TIMEOUT cycles, then one release cycle.
- Branch: 1+FLUSH_CYCLES consecutive cycles with reg1_clr=1.
- Simultaneous events: load-wait beats branch beats RAW beats HALT. A HALT in decode during a taken branch is squashed and does not enter HALTED. resume outside HALTED has no effect.

## Test plan
- Back-to-back dependency: producer writes x3, next instruction reads x3 → pc_halt=1, reg1_clr=1 for 2 cycles, then the consumer issues; stall_cnt=2.
- Load with mem_ready low 3 cycles → pc_halt=reg1_halt=reg2_halt=1 for 3 cycles, state=1, release on the 4th cycle; a load with immediate mem_ready gives no stall.
- Load with mem_ready never asserted, MEM_TIMEOUT=16 → 16 freeze cycles, then release, mem_err=1 and stays 1 until nrst.
- Taken branch with FLUSH_CYCLES=1 and HALT in decode → reg1_clr high for 2 cycles, pc_halt=0, state returns to RUN, never enters HALTED.
- HALT instruction → state=3, pc_halt=1 held for 10 cycles while the pipeline drains; resume pulse → RUN the next cycle.
- nrst asserted mid-LOAD_WAIT → state=RUN, mem_err=0, stall_cnt=0 asynchronously.
